mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters; only 4 is supported.
REQ-002 SHALL have parameter ADDR_W, default 4, main-memory word address width.
REQ-003 SHALL have parameter DATA_W, default 32, main-memory word width.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on posedge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req  in  4  per-requester transaction request.
REQ-007 SHALL have port we  in  4  per-requester write enable (1 = write, 0 = read).
REQ-008 SHALL have port addr_i  in  16  packed 4x4 request addresses; requester k uses bits [4k+3:4k].
REQ-009 SHALL have port wdata_i  in  128  packed 4x32 write data; requester k uses bits [32k+31:32k].
REQ-010 SHALL have port gnt  out  4  one-hot grant.
REQ-011 SHALL have port ack  out  4  one-hot, one-cycle completion pulse.
REQ-012 SHALL have port rdata  out  32  read data of the completing transaction.
REQ-013 SHALL have port rtag  out  2  tag of the completing transaction, equal to its address[3:2].
REQ-014 SHALL have port mem_addr_rd  out  4  memory read-port address.
REQ-015 SHALL have port mem_rdata  in  32  memory read-port data; combinational from mem_addr_rd.
REQ-016 SHALL have port mem_we  out  1  memory write strobe.
REQ-017 SHALL have port mem_addr_wr  out  4  memory write address.
REQ-018 SHALL have port mem_wdata  out  32  memory write data.
REQ-019 SHALL have port inv_valid  out  1  write-invalidate broadcast.
REQ-020 SHALL have port inv_addr  out  4  address being invalidated.
REQ-021 SHALL have port inv_src  out  2  id of the writing requester.
REQ-022 SHALL have port busy  out  1  high whenever state is not IDLE.

Function
REQ-023 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE, one cycle each in ACCESS and DONE.
REQ-024 In IDLE with any req high, SHALL select a winner round-robin starting at pointer ptr, latch id/we/addr/wdata, and enter ACCESS; with no req it SHALL stay in IDLE.
REQ-025 In ACCESS, SHALL drive mem_addr_rd = latched addr and capture mem_rdata into rdata at the closing edge.
REQ-026 In ACCESS of a write, SHALL assert mem_we, mem_addr_wr and mem_wdata for exactly one cycle, and assert inv_valid/inv_addr/inv_src in the same cycle.
REQ-027 A write SHALL return the pre-write contents on rdata (read-before-write).
REQ-028 SHALL assert gnt[id] during ACCESS and DONE, and ack[id] during DONE only, with rdata/rtag valid during DONE.
REQ-029 Latency from req sampled in IDLE to ack high SHALL be 2 cycles; a new arbitration SHALL be possible every 3 cycles.
REQ-030 In DONE, SHALL set ptr <= (id+1) mod 4, wrapping 3 -> 0.
REQ-031 Requesters SHALL hold req/we/addr/wdata stable until ack, and inputs other than the winner's SHALL be ignored outside IDLE.
REQ-032 A req dropped before ack SHALL NOT abort the transaction, which SHALL complete normally.
REQ-033 mem_we and inv_valid SHALL be 0 in every state other than ACCESS of a write; mem_addr_* SHALL be 0 in IDLE.

Reset
REQ-034 rst high SHALL immediately force state = IDLE, ptr = 0, and gnt, ack, rdata, rtag, mem_*, inv_*, busy = 0.
REQ-035 rst asserted mid-transaction SHALL abandon it, so that no ack and no further mem_we occurs; a write already clocked into memory is not undone.

Structure
REQ-036 Package mem_arb_pkg SHALL hold NUM_REQ, ADDR_W, DATA_W and the state enum type.
REQ-037 Sub-module rr_pick (combinational; inputs req[3:0] and ptr[1:0]; outputs id[1:0] and any) SHALL implement the round-robin selection.

Verification
REQ-038 Single read: req=0001, addr_i[3:0]=4 with mem[4]=1 -> ack=0001 two cycles later, rdata=1, rtag=01.
REQ-039 Single write: req=0100, we=0100, addr=14, wdata=0xA5 -> mem_we one cycle at addr 14, inv_valid with inv_addr=14 and inv_src=2, rdata=old mem[14]=7.
REQ-040 Fairness: req=1111 held continuously from reset -> ack order 0,1,2,3,0 at 3-cycle spacing.
REQ-041 Wrap: after a grant to id 3 with req=1001 -> next ack goes to id 0.
REQ-042 Reset mid-ACCESS of a write -> all outputs 0 immediately, no ack follows, ptr=0 afterwards.
REQ-043 Idle: req=0000 for 10 cycles -> busy, gnt and mem_we stay 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants, state encoding and helpers for the four-requester memory arbiter.
package mem_arb_pkg;
    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 32;
    localparam int ID_W    = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << id;
    endfunction
endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Round-robin winner selection: first requester at or after ptr, wrapping.
module rr_pick
    import mem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    id,
    output logic               any
);
    logic [ID_W-1:0] cand;

    // Walk from the farthest offset down so the nearest requester wins last.
    always_comb begin
        id   = ptr;
        any  = |req;
        cand = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + ID_W'(k);
            if (req[cand]) begin
                id = cand;
            end
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: round-robin grant, one access per three cycles,
// read-before-write data return and write-invalidate broadcast.
//
// state  | meaning
// IDLE   | waiting; arbitrate and latch winner when any req is high
// ACCESS | memory read of latched addr; write strobe + invalidate for writes
// DONE   | ack pulse with rdata/rtag; advance round-robin pointer
module mem_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         we,
    input  logic [NUM_REQ*ADDR_W-1:0]  addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]  wdata_i,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         ack,
    output logic [DATA_W-1:0]          rdata,
    output logic [1:0]                 rtag,
    output logic [ADDR_W-1:0]          mem_addr_rd,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr_wr,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic                       inv_valid,
    output logic [ADDR_W-1:0]          inv_addr,
    output logic [1:0]                 inv_src,
    output logic                       busy
);
    import mem_arb_pkg::*;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   id_q;
    logic [ID_W-1:0]   pick_id;
    logic              pick_any;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    rr_pick u_rr_pick (
        .req (req),
        .ptr (ptr),
        .id  (pick_id),
        .any (pick_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            id_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        id_q    <= pick_id;
                        we_q    <= we[pick_id];
                        addr_q  <= addr_i[pick_id*ADDR_W +: ADDR_W];
                        wdata_q <= wdata_i[pick_id*DATA_W +: DATA_W];
                    end
                end
                // Memory write lands on this same edge, so the captured word is the old one.
                ACCESS:  rdata_q <= mem_rdata;
                DONE:    ptr     <= id_q + 2'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt   = state;
        gnt         = '0;
        ack         = '0;
        busy        = 1'b0;
        rtag        = '0;
        mem_addr_rd = '0;
        mem_we      = 1'b0;
        mem_addr_wr = '0;
        mem_wdata   = '0;
        inv_valid   = 1'b0;
        inv_addr    = '0;
        inv_src     = '0;
        case (state)
            IDLE: begin
                if (pick_any) state_nxt = ACCESS;
            end
            ACCESS: begin
                state_nxt   = DONE;
                busy        = 1'b1;
                gnt         = onehot(id_q);
                mem_addr_rd = addr_q;
                if (we_q) begin
                    mem_we      = 1'b1;
                    mem_addr_wr = addr_q;
                    mem_wdata   = wdata_q;
                    inv_valid   = 1'b1;
                    inv_addr    = addr_q;
                    inv_src     = id_q;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                busy      = 1'b1;
                gnt       = onehot(id_q);
                ack       = onehot(id_q);
                rtag      = addr_q[ADDR_W-1 -: 2];
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rdata = rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared each cycle against a transaction-level reference model.
module tb_mem_arbiter;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [3:0]   req = '0;
    logic [3:0]   we = '0;
    logic [15:0]  addr_i = '0;
    logic [127:0] wdata_i = '0;
    logic [3:0]   gnt, ack;
    logic [31:0]  rdata;
    logic [1:0]   rtag;
    logic [3:0]   mem_addr_rd;
    logic [31:0]  mem_rdata;
    logic         mem_we;
    logic [3:0]   mem_addr_wr;
    logic [31:0]  mem_wdata;
    logic         inv_valid;
    logic [3:0]   inv_addr;
    logic [1:0]   inv_src;
    logic         busy;

    int vectors = 0;
    int miscompares = 0;

    mem_arbiter #(.NUM_REQ(4), .ADDR_W(4), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr_i(addr_i), .wdata_i(wdata_i),
        .gnt(gnt), .ack(ack), .rdata(rdata), .rtag(rtag),
        .mem_addr_rd(mem_addr_rd), .mem_rdata(mem_rdata), .mem_we(mem_we),
        .mem_addr_wr(mem_addr_wr), .mem_wdata(mem_wdata),
        .inv_valid(inv_valid), .inv_addr(inv_addr), .inv_src(inv_src), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 4)  return 32'd1;
        if (i == 14) return 32'd7;
        return 32'h1000_0000 + 32'(i * 32'h0101);
    endfunction

    // Memory environment: combinational read, write on the clock edge.
    logic [31:0] mem [16];
    assign mem_rdata = mem[mem_addr_rd];
    initial for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
    always @(posedge clk) if (mem_we) mem[mem_addr_wr] <= mem_wdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int ack_id();
        for (int k = 0; k < 4; k++) if (ack[k]) return k;
        return -1;
    endfunction

    // Reference model: one transaction at a time; ACCESS is the cycle after the
    // arbitration cycle, DONE the one after that.
    logic [31:0] ref_mem [16];
    logic        mdl_init = 1'b0;
    logic        pend = 1'b0;
    int          cyc = 0;
    int          t_acc = 0;
    int          m_ptr = 0;
    int          m_id = 0;
    logic        m_we = 1'b0;
    logic [3:0]  m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_rd = '0;
    logic        in_acc, in_done, found;
    logic [3:0]  e_oh;

    always @(negedge clk) begin
        cyc++;
        if (!mdl_init) begin
            for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
            mdl_init = 1'b1;
        end
        if (rst) begin
            chk("rst_gnt", 32'(gnt), 0);
            chk("rst_ack", 32'(ack), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_mem_we", 32'(mem_we), 0);
            chk("rst_inv_valid", 32'(inv_valid), 0);
            chk("rst_rdata", rdata, 0);
            pend  = 1'b0;
            m_ptr = 0;
        end else begin
            in_acc  = pend && (cyc == t_acc);
            in_done = pend && (cyc == t_acc + 1);
            e_oh    = 4'(1 << m_id);
            chk("gnt", 32'(gnt), (in_acc || in_done) ? 32'(e_oh) : 0);
            chk("ack", 32'(ack), in_done ? 32'(e_oh) : 0);
            chk("busy", 32'(busy), 32'(in_acc || in_done));
            chk("mem_we", 32'(mem_we), 32'(in_acc && m_we));
            chk("inv_valid", 32'(inv_valid), 32'(in_acc && m_we));
            if (!pend) begin
                chk("idle_mem_addr_rd", 32'(mem_addr_rd), 0);
                chk("idle_mem_addr_wr", 32'(mem_addr_wr), 0);
            end
            if (in_acc) begin
                chk("mem_addr_rd", 32'(mem_addr_rd), 32'(m_addr));
                if (m_we) begin
                    chk("mem_addr_wr", 32'(mem_addr_wr), 32'(m_addr));
                    chk("mem_wdata", mem_wdata, m_wdata);
                    chk("inv_addr", 32'(inv_addr), 32'(m_addr));
                    chk("inv_src", 32'(inv_src), 32'(m_id));
                end
            end
            if (in_done) begin
                chk("rdata", rdata, m_rd);
                chk("rtag", 32'(rtag), 32'(m_addr[3:2]));
            end

            if (in_acc && m_we) ref_mem[m_addr] = m_wdata;
            if (in_done) begin
                pend  = 1'b0;
                m_ptr = (m_id + 1) % 4;
            end else if (!pend && req != 4'b0) begin
                found = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    if (!found && req[(m_ptr + k) % 4]) begin
                        found = 1'b1;
                        m_id  = (m_ptr + k) % 4;
                    end
                end
                pend    = 1'b1;
                t_acc   = cyc + 1;
                m_we    = we[m_id];
                m_addr  = addr_i[4*m_id +: 4];
                m_wdata = wdata_i[32*m_id +: 32];
                m_rd    = ref_mem[m_addr];
            end
        end
    end

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack == 4'b0 && n < 20);
        if (ack == 4'b0) chk("ack_timeout", 32'(n), 3);
    endtask

    task automatic check_all_zero(input string pfx);
        chk({pfx, "_gnt"}, 32'(gnt), 0);
        chk({pfx, "_ack"}, 32'(ack), 0);
        chk({pfx, "_busy"}, 32'(busy), 0);
        chk({pfx, "_rdata"}, rdata, 0);
        chk({pfx, "_rtag"}, 32'(rtag), 0);
        chk({pfx, "_mem_addr_rd"}, 32'(mem_addr_rd), 0);
        chk({pfx, "_mem_we"}, 32'(mem_we), 0);
        chk({pfx, "_mem_addr_wr"}, 32'(mem_addr_wr), 0);
        chk({pfx, "_mem_wdata"}, mem_wdata, 0);
        chk({pfx, "_inv_valid"}, 32'(inv_valid), 0);
        chk({pfx, "_inv_addr"}, 32'(inv_addr), 0);
        chk({pfx, "_inv_src"}, 32'(inv_src), 0);
    endtask

    int n;

    initial begin
        #1 rst = 1'b1;
        #2 check_all_zero("reset");
        @(posedge clk); #1; rst = 1'b0;

        // Single read of mem[4]
        req = 4'b0001; we = 4'b0000; addr_i = 16'h0004;
        wait_ack(n);
        chk("rd_latency", 32'(n), 3);
        chk("rd_ack", 32'(ack), 32'h1);
        chk("rd_rdata", rdata, 32'd1);
        chk("rd_rtag", 32'(rtag), 32'h1);

        // Single write from requester 2 to address 14
        @(posedge clk); #1;
        req = 4'b0100; we = 4'b0100; addr_i = 16'h0E00;
        wdata_i = '0; wdata_i[95:64] = 32'hA5;
        @(negedge clk);
        @(negedge clk);
        chk("wr_mem_we", 32'(mem_we), 1);
        chk("wr_mem_addr_wr", 32'(mem_addr_wr), 14);
        chk("wr_mem_wdata", mem_wdata, 32'hA5);
        chk("wr_inv_valid", 32'(inv_valid), 1);
        chk("wr_inv_addr", 32'(inv_addr), 14);
        chk("wr_inv_src", 32'(inv_src), 2);
        @(negedge clk);
        chk("wr_ack", 32'(ack), 32'h4);
        chk("wr_rdata_old", rdata, 32'd7);
        chk("wr_rtag", 32'(rtag), 32'h3);
        @(posedge clk); #1; req = 4'b0; we = 4'b0;
        @(negedge clk);
        chk("wr_mem14", mem[14], 32'hA5);

        // Idle
        repeat (10) begin
            @(negedge clk);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_gnt", 32'(gnt), 0);
            chk("idle_mem_we", 32'(mem_we), 0);
        end

        // Fairness from reset with all requesters active
        @(posedge clk); #1; rst = 1'b1;
        req = 4'b1111; we = 4'b0; addr_i = 16'h3210;
        @(posedge clk); #1; rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_ack(n);
            chk("fair_spacing", 32'(n), 3);
            chk("fair_id", 32'(ack_id()), 32'(i % 4));
        end

        // Wrap: grant to 3, then 0 wins over 3
        @(posedge clk); #1; req = 4'b1000;
        wait_ack(n);
        chk("wrap_first", 32'(ack_id()), 3);
        @(posedge clk); #1; req = 4'b1001;
        wait_ack(n);
        chk("wrap_second", 32'(ack_id()), 0);

        // Reset in the ACCESS cycle of a write (pointer is 1 here)
        @(posedge clk); #1;
        req = 4'b0100; we = 4'b0100; addr_i = 16'h0E00;
        wdata_i = '0; wdata_i[95:64] = 32'h5A;
        @(negedge clk);
        @(posedge clk); #1;
        chk("mr_mem_we_before", 32'(mem_we), 1);
        rst = 1'b1;
        #1 check_all_zero("mid_reset");
        @(posedge clk); #1;
        rst = 1'b0; req = 4'b1111; we = 4'b0; addr_i = 16'h3210;
        wait_ack(n);
        chk("post_reset_id", 32'(ack_id()), 0);
        chk("post_reset_latency", 32'(n), 3);
        chk("post_reset_mem14", mem[14], 32'hA5);

        // Randomized traffic; the current winner holds its request fields
        @(posedge clk); #1; req = 4'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 4; k++) begin
                if (pend && m_id == k) begin
                    if ($urandom_range(3) == 0) req[k] = 1'b0;
                end else begin
                    req[k] = 1'($urandom_range(1));
                    we[k]  = 1'($urandom_range(1));
                    addr_i[4*k +: 4]   = 4'($urandom_range(15));
                    wdata_i[32*k +: 32] = $urandom;
                end
            end
        end
        @(posedge clk); #1; req = 4'b0;
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
